// File: rtl/input_flit_requester_pkg.sv
// Shared router types: flit type encoding, flit word and requester FSM states.
// Flit layout: [W-1:W-2] type, low bits carry the destination port on head flits.
package input_flit_requester_pkg;

    localparam int FLIT_W = 34;

    typedef enum logic [1:0] {
        FT_HEAD      = 2'b00,
        FT_BODY      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DROP
    } state_e;

    function automatic logic is_head(input flit_type_e t);
        return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Input flit buffer: power-of-two depth, registered storage, top of queue shown combinationally.
// Pushes are refused when full; pops are ignored when empty.
module flit_fifo #(
    parameter int FLIT_WIDTH = 34,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  push,
    input  logic [FLIT_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [FLIT_WIDTH-1:0] top_data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign top_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/input_flit_requester.sv
// Router input port: buffers flits, requests the head flit's output port and
// streams the packet once granted; malformed flits and packets are dropped.
module input_flit_requester
    import input_flit_requester_pkg::*;
#(
    parameter int N_OUTPUTS  = 5,
    parameter int FLIT_WIDTH = 34,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  fin_valid_i,
    input  logic [FLIT_WIDTH-1:0] fin_data_i,
    output logic                  fin_ready_o,
    output logic [N_OUTPUTS-1:0]  req_o,
    input  logic [N_OUTPUTS-1:0]  grant_i,
    output logic                  fout_valid_o,
    output logic [FLIT_WIDTH-1:0] fout_data_o,
    input  logic                  fout_ready_i,
    output logic [N_OUTPUTS-1:0]  release_o,
    output logic                  err_o
);

    localparam int DEST_W = $clog2(N_OUTPUTS);

    state_e                state;
    state_e                state_next;
    logic [DEST_W-1:0]     dest_ff;
    logic                  load_dest;
    logic                  pop;
    logic [FLIT_WIDTH-1:0] top_data;
    logic                  empty;
    logic                  full;
    flit_type_e            top_type;
    logic [DEST_W-1:0]     top_dest;
    logic                  dest_ok;

    flit_fifo #(
        .FLIT_WIDTH(FLIT_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (fin_valid_i),
        .push_data(fin_data_i),
        .pop      (pop),
        .top_data (top_data),
        .empty    (empty),
        .full     (full)
    );

    assign fin_ready_o = !full;
    assign fout_data_o = top_data;
    assign top_type    = flit_type_e'(top_data[FLIT_WIDTH-1:FLIT_WIDTH-2]);
    assign top_dest    = top_data[DEST_W-1:0];
    assign dest_ok     = 32'(top_dest) < 32'(N_OUTPUTS);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= ST_IDLE;
            dest_ff <= '0;
        end else begin
            state <= state_next;
            if (load_dest) begin
                dest_ff <= top_dest;
            end
        end
    end

    // The head flit stays buffered through REQ so it is the first flit transferred.
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        load_dest    = 1'b0;
        err_o        = 1'b0;
        release_o    = '0;
        req_o        = '0;
        fout_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    if (is_head(top_type)) begin
                        if (dest_ok) begin
                            load_dest  = 1'b1;
                            state_next = ST_REQ;
                        end else begin
                            err_o = 1'b1;
                            pop   = 1'b1;
                            if (top_type == FT_HEAD) begin
                                state_next = ST_DROP;
                            end
                        end
                    end else begin
                        err_o = 1'b1;
                        pop   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_o[dest_ff] = 1'b1;
                if (grant_i[dest_ff]) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                req_o[dest_ff] = 1'b1;
                fout_valid_o   = !empty;
                if (!empty && fout_ready_i) begin
                    pop = 1'b1;
                    if (is_tail(top_type)) begin
                        release_o[dest_ff] = 1'b1;
                        state_next         = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (top_type == FT_TAIL) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_input_flit_requester.sv
// Directed bench for input_flit_requester: inputs change 1 time unit after the
// rising edge, outputs are checked on the falling edge.
module tb_input_flit_requester;
    import input_flit_requester_pkg::*;

    logic        clk;
    logic        arst;
    logic        fin_valid;
    flit_t       fin_data;
    logic        fin_ready;
    logic [4:0]  req;
    logic [4:0]  grant;
    logic        fout_valid;
    flit_t       fout_data;
    logic        fout_ready;
    logic [4:0]  rel;
    logic        err;

    int tests;
    int fails;

    input_flit_requester #(
        .N_OUTPUTS (5),
        .FLIT_WIDTH(34),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_valid_i (fin_valid),
        .fin_data_i  (fin_data),
        .fin_ready_o (fin_ready),
        .req_o       (req),
        .grant_i     (grant),
        .fout_valid_o(fout_valid),
        .fout_data_o (fout_data),
        .fout_ready_i(fout_ready),
        .release_o   (rel),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic flit_t mk(input flit_type_e t, input int dest, input int pl);
        return {t, 29'(pl), 3'(dest)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        arst       = 1'b1;
        fin_valid  = 1'b0;
        fin_data   = '0;
        grant      = '0;
        fout_ready = 1'b0;

        // Reset values
        smp();
        check("rst_req", 64'(req), 64'd0);
        check("rst_rel", 64'(rel), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_valid", 64'(fout_valid), 64'd0);
        check("rst_ready", 64'(fin_ready), 64'd1);
        check("rst_count", 64'(dut.u_fifo.count), 64'd0);
        cyc(); arst = 1'b0;

        // Three-flit packet to port 2
        cyc(); fin_valid = 1'b1; fin_data = mk(FT_HEAD, 2, 'h11); smp();
        check("a_ready", 64'(fin_ready), 64'd1);
        check("a_req_n0", 64'(req), 64'd0);
        cyc(); fin_data = mk(FT_BODY, 0, 'h22); smp();
        check("a_req_n1", 64'(req), 64'd0);
        cyc(); fin_data = mk(FT_TAIL, 0, 'h33); smp();
        check("a_req_n2", 64'(req), 64'b00100);
        cyc(); fin_valid = 1'b0; grant = 5'b00100; fout_ready = 1'b1; smp();
        check("a_valid_in_req", 64'(fout_valid), 64'd0);
        cyc(); grant = '0; smp();
        check("a_hs1_valid", 64'(fout_valid), 64'd1);
        check("a_hs1_data", 64'(fout_data), 64'(mk(FT_HEAD, 2, 'h11)));
        check("a_hs1_rel", 64'(rel), 64'd0);
        cyc(); smp();
        check("a_hs2_valid", 64'(fout_valid), 64'd1);
        check("a_hs2_data", 64'(fout_data), 64'(mk(FT_BODY, 0, 'h22)));
        check("a_hs2_rel", 64'(rel), 64'd0);
        cyc(); smp();
        check("a_hs3_data", 64'(fout_data), 64'(mk(FT_TAIL, 0, 'h33)));
        check("a_hs3_rel", 64'(rel), 64'b00100);
        cyc(); smp();
        check("a_done_req", 64'(req), 64'd0);
        check("a_done_valid", 64'(fout_valid), 64'd0);
        check("a_done_rel", 64'(rel), 64'd0);
        check("a_done_count", 64'(dut.u_fifo.count), 64'd0);

        // Single-flit packet to port 0 with output backpressure
        cyc(); fout_ready = 1'b0; fin_valid = 1'b1; fin_data = mk(FT_HEAD_TAIL, 0, 'h44); smp();
        cyc(); fin_valid = 1'b0; smp();
        check("b_req_n1", 64'(req), 64'd0);
        cyc(); grant = 5'b00001; smp();
        check("b_req", 64'(req), 64'b00001);
        for (int i = 0; i < 3; i++) begin
            cyc(); grant = (i == 0) ? 5'b11110 : 5'b00000; smp();
            check("b_stall_valid", 64'(fout_valid), 64'd1);
            check("b_stall_data", 64'(fout_data), 64'(mk(FT_HEAD_TAIL, 0, 'h44)));
            check("b_stall_rel", 64'(rel), 64'd0);
        end
        cyc(); fout_ready = 1'b1; smp();
        check("b_hs_valid", 64'(fout_valid), 64'd1);
        check("b_hs_rel", 64'(rel), 64'b00001);
        cyc(); fout_ready = 1'b0; smp();
        check("b_done_valid", 64'(fout_valid), 64'd0);
        check("b_done_req", 64'(req), 64'd0);
        check("b_done_rel", 64'(rel), 64'd0);

        // Fill the buffer without a grant, then drain to port 1
        for (int i = 0; i < 4; i++) begin
            cyc(); fin_valid = 1'b1;
            fin_data = (i == 0) ? mk(FT_HEAD, 1, 'h50) : mk(FT_BODY, 0, 'h51 + i);
            smp();
            check("c_ready_fill", 64'(fin_ready), 64'd1);
        end
        cyc(); fin_data = mk(FT_TAIL, 0, 'h5f); smp();
        check("c_full_ready", 64'(fin_ready), 64'd0);
        check("c_full_count", 64'(dut.u_fifo.count), 64'd4);
        cyc(); fin_valid = 1'b0; grant = 5'b00010; fout_ready = 1'b1; smp();
        check("c_refused_count", 64'(dut.u_fifo.count), 64'd4);
        check("c_req", 64'(req), 64'b00010);
        cyc(); grant = '0; smp();
        check("c_hs_head", 64'(fout_data), 64'(mk(FT_HEAD, 1, 'h50)));
        check("c_hs_head_count", 64'(dut.u_fifo.count), 64'd4);
        cyc(); fin_valid = 1'b1; fin_data = mk(FT_TAIL, 0, 'h5f); smp();
        check("c_ready_after_pop", 64'(fin_ready), 64'd1);
        check("c_count_3", 64'(dut.u_fifo.count), 64'd3);
        check("c_hs_b1", 64'(fout_data), 64'(mk(FT_BODY, 0, 'h52)));
        cyc(); fin_valid = 1'b0; smp();
        check("c_pushpop_count", 64'(dut.u_fifo.count), 64'd3);
        check("c_hs_b2", 64'(fout_data), 64'(mk(FT_BODY, 0, 'h53)));
        cyc(); smp();
        check("c_hs_b3", 64'(fout_data), 64'(mk(FT_BODY, 0, 'h54)));
        cyc(); smp();
        check("c_hs_tail", 64'(fout_data), 64'(mk(FT_TAIL, 0, 'h5f)));
        check("c_rel", 64'(rel), 64'b00010);
        cyc(); fout_ready = 1'b0; smp();
        check("c_done_req", 64'(req), 64'd0);
        check("c_done_count", 64'(dut.u_fifo.count), 64'd0);

        // Head with out-of-range destination drops the whole packet
        cyc(); fin_valid = 1'b1; fin_data = mk(FT_HEAD, 6, 'h60); smp();
        check("d_err_n0", 64'(err), 64'd0);
        cyc(); fin_data = mk(FT_BODY, 0, 'h61); smp();
        check("d_err_pulse", 64'(err), 64'd1);
        check("d_req_0", 64'(req), 64'd0);
        cyc(); fin_data = mk(FT_TAIL, 0, 'h62); smp();
        check("d_err_body", 64'(err), 64'd0);
        check("d_req_1", 64'(req), 64'd0);
        cyc(); fin_valid = 1'b0; smp();
        check("d_err_tail", 64'(err), 64'd0);
        check("d_valid", 64'(fout_valid), 64'd0);
        cyc(); smp();
        check("d_done_count", 64'(dut.u_fifo.count), 64'd0);
        check("d_done_req", 64'(req), 64'd0);
        check("d_done_err", 64'(err), 64'd0);

        // Stray body flit, then a normal head to port 1
        cyc(); fin_valid = 1'b1; fin_data = mk(FT_BODY, 0, 'h70); smp();
        cyc(); fin_data = mk(FT_HEAD, 1, 'h71); smp();
        check("e_err_pulse", 64'(err), 64'd1);
        cyc(); fin_valid = 1'b0; smp();
        check("e_err_clear", 64'(err), 64'd0);
        check("e_req_n1", 64'(req), 64'd0);
        cyc(); smp();
        check("e_req", 64'(req), 64'b00010);
        cyc(); arst = 1'b1; smp();
        check("e_rst_req", 64'(req), 64'd0);
        cyc(); arst = 1'b0;

        // Reset in the middle of a transfer to port 3
        cyc(); fin_valid = 1'b1; fin_data = mk(FT_HEAD, 3, 'h80); smp();
        cyc(); fin_data = mk(FT_BODY, 0, 'h81); smp();
        cyc(); fin_data = mk(FT_TAIL, 0, 'h82); smp();
        check("f_req", 64'(req), 64'b01000);
        cyc(); fin_valid = 1'b0; grant = 5'b01000; fout_ready = 1'b1; smp();
        cyc(); grant = '0; smp();
        check("f_hs_head", 64'(fout_data), 64'(mk(FT_HEAD, 3, 'h80)));
        check("f_hs_valid", 64'(fout_valid), 64'd1);
        cyc(); arst = 1'b1; smp();
        check("f_rst_req", 64'(req), 64'd0);
        check("f_rst_rel", 64'(rel), 64'd0);
        check("f_rst_valid", 64'(fout_valid), 64'd0);
        check("f_rst_err", 64'(err), 64'd0);
        check("f_rst_ready", 64'(fin_ready), 64'd1);
        check("f_rst_count", 64'(dut.u_fifo.count), 64'd0);
        cyc(); arst = 1'b0; smp();
        check("f_post_rel", 64'(rel), 64'd0);
        check("f_post_valid", 64'(fout_valid), 64'd0);
        check("f_post_req", 64'(req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_flit_requester.md
INPUT_FLIT_REQUESTER -- requirements
Module: input_flit_requester

Interface
REQ-001 Parameter N_OUTPUTS, default 5: number of router output ports; one arbiter request/grant bit per port.
REQ-002 Parameter FLIT_WIDTH, default 34: total flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type.
REQ-003 Parameter FIFO_DEPTH, default 4: input buffer depth; power of two, at least 2.
REQ-004 Derived DEST_W = $clog2(N_OUTPUTS): destination port field width, head flit bits [DEST_W-1:0].
REQ-005 Signal clk, input, 1: clock. Reset arst, asynchronous, active-high; clock clk.
REQ-006 Signal arst, input, 1: asynchronous active-high reset.
REQ-007 Signal fin_valid_i, input, 1: upstream flit valid.
REQ-008 Signal fin_data_i, input, FLIT_WIDTH: upstream flit.
REQ-009 Signal fin_ready_o, output, 1: buffer can accept a flit.
REQ-010 Signal req_o, output, N_OUTPUTS: one-hot request to the output-port round-robin arbiters.
REQ-011 Signal grant_i, input, N_OUTPUTS: registered grant from the arbiters for this input.
REQ-012 Signal fout_valid_o, output, 1: flit presented to the granted output.
REQ-013 Signal fout_data_o, output, FLIT_WIDTH: FIFO head flit.
REQ-014 Signal fout_ready_i, input, 1: ready of the granted output.
REQ-015 Signal release_o, output, N_OUTPUTS: one-cycle one-hot pulse on tail handshake; the output port uses it as the arbiter update.
REQ-016 Signal err_o, output, 1: one-cycle pulse when a malformed flit or packet is dropped.

Function
REQ-017 Flit types SHALL be 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL; a HEAD_TAIL flit is a single-flit packet.
REQ-018 The FIFO SHALL accept a flit when fin_valid_i and fin_ready_o are both high, with fin_ready_o = not full.
REQ-019 A flit pushed in cycle N SHALL be visible at the FIFO top in cycle N+1; push and pop in the same cycle SHALL leave the count unchanged.
REQ-020 The FSM SHALL have four states: IDLE, REQ, XFER and DROP.
REQ-021 IDLE, top is HEAD/HEAD_TAIL with dest < N_OUTPUTS: capture dest_ff and go to REQ.
REQ-022 IDLE, top is HEAD/HEAD_TAIL with dest >= N_OUTPUTS: pulse err_o, pop; HEAD goes to DROP, HEAD_TAIL stays in IDLE.
REQ-023 IDLE, top is BODY/TAIL: pop, pulse err_o, stay in IDLE.
REQ-024 req_o[dest_ff] SHALL be high in REQ and XFER and zero in every other state.
REQ-025 REQ, grant_i[dest_ff] sampled high: go to XFER; grant bits other than dest_ff SHALL be ignored.
REQ-026 fout_valid_o = (state==XFER) and FIFO not empty; each fout_valid_o and fout_ready_i handshake pops one flit.
REQ-027 XFER, TAIL/HEAD_TAIL handshake: pulse release_o[dest_ff] in the same cycle, drop req_o next cycle, go to IDLE.
REQ-028 XFER SHALL ignore grant_i, and FIFO underflow mid-packet SHALL stall with fout_valid_o low.
REQ-029 DROP: pop every available flit without output handshake; on TAIL go to IDLE.
REQ-030 Latency: a HEAD pushed in cycle N raises req_o in N+2; a grant sampled in cycle G raises fout_valid_o in G+1.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-032 arst SHALL force state IDLE, FIFO empty, dest_ff 0, req_o 0, release_o 0, err_o 0, fout_valid_o 0 and fin_ready_o 1.
REQ-033 arst mid-packet SHALL discard buffered flits with no release_o pulse.

Structure
REQ-034 The flit-type enum, the flit typedef and the FSM state enum SHALL live in the shared router package.
REQ-035 The FIFO SHALL be a sub-module named flit_fifo (parameters FLIT_WIDTH, FIFO_DEPTH), with the FSM in this module.

Verification
REQ-036 Reset then push HEAD dest=2, BODY, TAIL, grant_i=00100 one cycle after req_o -> req_o=00100, three handshakes, release_o=00100 with the TAIL.
REQ-037 HEAD_TAIL dest=0, fout_ready_i low for 3 cycles after grant -> fout_valid_o held with data stable; single handshake; release_o=00001.
REQ-038 Push 5 flits back-to-back with no grant -> fin_ready_o low after the 4th; 5th not accepted; count stays 4.
REQ-039 HEAD dest=6 (N_OUTPUTS=5), BODY, TAIL -> err_o one pulse, all three dropped, req_o stays 0.
REQ-040 BODY as first flit -> err_o pulse, flit dropped, next valid HEAD dest=1 requests normally.
REQ-041 arst asserted during XFER after 1 of 3 flits -> all outputs 0, fin_ready_o=1, no release_o.
